// File: rtl/hub75_pkg.sv
// Shared constants and state encoding for the HUB75 scan controller.
// Build macro HUB75_GHOST_BLANK_EN lengthens the pre-latch blanking interval.
package hub75_pkg;

  localparam int NUM_COLS = 64;
  localparam int NUM_ROWS = 16;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int ROW_W    = $clog2(NUM_ROWS);

`ifdef HUB75_GHOST_BLANK_EN
  // Extra dark time lets the previous row's drivers discharge before the address moves.
  localparam int BLANK_TICKS = 4;
`else
  localparam int BLANK_TICKS = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

endpackage

// File: rtl/hub75_tick_gen.sv
// Scan tick divider: one-cycle tick every CLK_DIV clocks, restarted by clear.
module hub75_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [7:0] cnt_q;
  logic       wrap;

  assign wrap = (cnt_q == 8'(CLK_DIV - 1));
  assign tick = wrap && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan controller: shifts a row pair, blanks, latches, then displays it.
// Blanking length depends on the HUB75_GHOST_BLANK_EN build macro (see hub75_pkg).
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int ON_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [COL_W-1:0] fb_column,
  output logic [ROW_W-1:0] fb_addr,
  input  logic [2:0]       fb_rgb0,
  input  logic [2:0]       fb_rgb1,
  output logic             hub_clk,
  output logic             hub_lat,
  output logic             hub_oe_n,
  output logic [ROW_W-1:0] hub_addr,
  output logic [2:0]       hub_rgb0,
  output logic [2:0]       hub_rgb1,
  output logic             frame_done
);

  scan_state_e      state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             phase_q;
  logic [7:0]       cnt_q;
  logic             tick;
  logic             tick_clear;

  assign tick_clear = !enable;
  assign fb_column  = col_q;
  assign fb_addr    = row_q;

  hub75_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_addr   <= '0;
      hub_rgb0   <= '0;
      hub_rgb1   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Dropping enable aborts immediately; any partially shifted row is abandoned.
      if (!enable) begin
        state_q  <= ST_IDLE;
        col_q    <= '0;
        row_q    <= '0;
        phase_q  <= 1'b0;
        cnt_q    <= '0;
        hub_clk  <= 1'b0;
        hub_lat  <= 1'b0;
        hub_oe_n <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_SHIFT;
            col_q   <= '0;
            phase_q <= 1'b0;
          end
          ST_SHIFT: begin
            if (!phase_q) begin
              hub_rgb0 <= fb_rgb0;
              hub_rgb1 <= fb_rgb1;
              hub_clk  <= 1'b0;
              phase_q  <= 1'b1;
            end else begin
              hub_clk <= 1'b1;
              phase_q <= 1'b0;
              if (col_q == COL_W'(NUM_COLS - 1)) begin
                state_q <= ST_BLANK;
                cnt_q   <= '0;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          ST_BLANK: begin
            hub_clk <= 1'b0;
            if (cnt_q == 8'(BLANK_TICKS - 1)) begin
              state_q  <= ST_LATCH;
              hub_lat  <= 1'b1;
              hub_addr <= row_q;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_LATCH: begin
            hub_lat  <= 1'b0;
            hub_oe_n <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_DISPLAY;
          end
          ST_DISPLAY: begin
            if (cnt_q == 8'(ON_TICKS - 1)) begin
              hub_oe_n <= 1'b1;
              row_q    <= row_q + 1'b1;
              col_q    <= '0;
              state_q  <= ST_SHIFT;
              if (row_q == ROW_W'(NUM_ROWS - 1)) frame_done <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
